// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon block cipher core.
package simon_pkg;

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_LOAD = 4'b0010,
    ST_RUN  = 4'b0100,
    ST_DONE = 4'b1000
  } state_t;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  function automatic bit word_legal(input int w);
    return (w == 16) || (w == 24) || (w == 32) || (w == 48) || (w == 64);
  endfunction

endpackage

// File: rtl/simon_round.sv
// One combinational Simon round; the same f() feeds both directions.
module simon_round
  import simon_pkg::*;
#(
  parameter int WORD = 64
) (
  input  logic [WORD-1:0] i_x,
  input  logic [WORD-1:0] i_y,
  input  logic [WORD-1:0] i_k,
  input  logic            i_mode,
  output logic [WORD-1:0] o_x,
  output logic [WORD-1:0] o_y
);

  logic [WORD-1:0] w_a;
  logic [WORD-1:0] w_r1;
  logic [WORD-1:0] w_r2;
  logic [WORD-1:0] w_r8;
  logic [WORD-1:0] w_t;

  // Encrypt mixes f(x) into y; decrypt mixes f(y) into x.
  assign w_a  = (i_mode == MODE_DEC) ? i_y : i_x;
  assign w_r1 = {w_a[WORD-2:0], w_a[WORD-1]};
  assign w_r2 = {w_a[WORD-3:0], w_a[WORD-1 -: 2]};
  assign w_r8 = {w_a[WORD-9:0], w_a[WORD-1 -: 8]};
  assign w_t  = ((i_mode == MODE_DEC) ? i_x : i_y) ^ (w_r1 & w_r8) ^ w_r2 ^ i_k;

  assign o_x = (i_mode == MODE_DEC) ? i_y : w_t;
  assign o_y = (i_mode == MODE_DEC) ? w_t : i_x;

endmodule

// File: rtl/simon_core.sv
// Iterative Simon encrypt/decrypt core, one round per cycle, keys fetched
// from an external synchronous-read key memory.
module simon_core
  import simon_pkg::*;
#(
  parameter int WORD   = 64,
  parameter int ROUNDS = 72,
  parameter int KAW    = 7
) (
  input  logic              clk,
  input  logic              res,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2*WORD-1:0] in_block,
  input  logic              mode,
  output logic [KAW-1:0]    key_adr,
  input  logic [WORD-1:0]   key,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*WORD-1:0] out_block
);

  if (!word_legal(WORD)) begin : g_bad_word
    $error("simon_core: illegal WORD %0d", WORD);
  end
  if ((ROUNDS < 1) || (ROUNDS > 2**KAW)) begin : g_bad_rounds
    $error("simon_core: ROUNDS %0d out of range for KAW %0d", ROUNDS, KAW);
  end

  localparam logic [KAW-1:0] LAST = KAW'(ROUNDS - 1);
  localparam logic [KAW-1:0] ZERO = '0;
  localparam logic [KAW-1:0] ONE  = KAW'(1);

  state_t          r_state;
  logic            r_mode;
  logic [WORD-1:0] r_x;
  logic [WORD-1:0] r_y;
  logic [KAW-1:0]  r_adr;
  logic [KAW-1:0]  r_cnt;

  logic [WORD-1:0] w_x;
  logic [WORD-1:0] w_y;
  logic [KAW-1:0]  w_adr_nxt;

  simon_round #(.WORD(WORD)) u_round (
    .i_x    (r_x),
    .i_y    (r_y),
    .i_k    (key),
    .i_mode (r_mode),
    .o_x    (w_x),
    .o_y    (w_y)
  );

  // Address runs one cycle ahead of the round that consumes it, and parks at the end.
  always_comb begin
    w_adr_nxt = r_adr;
    if (r_mode == MODE_DEC) begin
      if (r_adr != ZERO) w_adr_nxt = r_adr - ONE;
    end else begin
      if (r_adr != LAST) w_adr_nxt = r_adr + ONE;
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_state <= ST_IDLE;
      r_mode  <= MODE_ENC;
      r_x     <= '0;
      r_y     <= '0;
      r_adr   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_x     <= in_block[2*WORD-1:WORD];
            r_y     <= in_block[WORD-1:0];
            r_mode  <= mode;
            r_adr   <= (mode == MODE_DEC) ? LAST : ZERO;
            r_cnt   <= '0;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_adr   <= w_adr_nxt;
          r_state <= ST_RUN;
        end
        ST_RUN: begin
          r_x   <= w_x;
          r_y   <= w_y;
          r_adr <= w_adr_nxt;
          r_cnt <= r_cnt + ONE;
          if (r_cnt == LAST) r_state <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign key_adr   = r_adr;
  assign out_block = {r_x, r_y};

endmodule

// File: tb/tb_simon_core.sv
// Randomized self-checking bench for simon_core: Simon32/64 and Simon128/256.
module tb_simon_core;
  import simon_pkg::*;

  logic clk = 1'b0;
  logic res = 1'b1;
  always #5 clk = ~clk;

  logic        v16, rdy16, m16, ov16, or16;
  logic [31:0] ib16, ob16;
  logic [4:0]  ka16;
  logic [15:0] k16;

  logic         v64, rdy64, m64, ov64, or64;
  logic [127:0] ib64, ob64;
  logic [6:0]   ka64;
  logic [63:0]  k64;

  simon_core #(.WORD(16), .ROUNDS(32), .KAW(5)) u16 (
    .clk(clk), .res(res), .in_valid(v16), .in_ready(rdy16), .in_block(ib16),
    .mode(m16), .key_adr(ka16), .key(k16), .out_valid(ov16),
    .out_ready(or16), .out_block(ob16));

  simon_core #(.WORD(64), .ROUNDS(72), .KAW(7)) u64 (
    .clk(clk), .res(res), .in_valid(v64), .in_ready(rdy64), .in_block(ib64),
    .mode(m64), .key_adr(ka64), .key(k64), .out_valid(ov64),
    .out_ready(or64), .out_block(ob64));

  logic [63:0] ks16[72];
  logic [63:0] ks64[72];

  always @(posedge clk) begin
    k16 <= ks16[ka16][15:0];
    k64 <= ks64[ka64];
  end

  int n_chk = 0;
  int n_err = 0;
  int adr_q[$];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Reference model: Simon on n-bit words held in 64-bit variables.
  function automatic logic [63:0] msk(input int n);
    return (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
  endfunction

  function automatic logic [63:0] rol(input logic [63:0] a, input int s, input int n);
    return ((a << s) | (a >> (n - s))) & msk(n);
  endfunction

  function automatic logic [63:0] ff(input logic [63:0] a, input int n);
    return (rol(a, 1, n) & rol(a, 8, n)) ^ rol(a, 2, n);
  endfunction

  function automatic logic [127:0] simon_ref(input int n, input int t, input bit dec,
                                             input logic [127:0] blk, input logic [63:0] ks[72]);
    logic [63:0] x, y, tmp;
    x = 64'(blk >> n) & msk(n);
    y = blk[63:0] & msk(n);
    for (int r = 0; r < t; r++) begin
      if (!dec) begin
        tmp = y ^ ff(x, n) ^ ks[r];
        y = x; x = tmp;
      end else begin
        tmp = x ^ ff(y, n) ^ ks[t-1-r];
        x = y; y = tmp;
      end
    end
    return (128'(x) << n) | 128'(y);
  endfunction

  task automatic expand(input int n, input int t, input logic [61:0] z,
                        input logic [63:0] mk0, input logic [63:0] mk1,
                        input logic [63:0] mk2, input logic [63:0] mk3,
                        output logic [63:0] ko[72]);
    logic [63:0] tmp;
    for (int i = 0; i < 72; i++) ko[i] = '0;
    ko[0] = mk0; ko[1] = mk1; ko[2] = mk2; ko[3] = mk3;
    for (int i = 4; i < t; i++) begin
      tmp = rol(ko[i-1], n - 3, n) ^ ko[i-3];
      tmp = tmp ^ rol(tmp, n - 1, n);
      ko[i] = (~ko[i-4] & msk(n)) ^ tmp ^ 64'(z[61 - ((i - 4) % 62)]) ^ 64'd3;
    end
  endtask

  // Called just after a negedge; returns just after the negedge following the take.
  task automatic xfer16(input bit md, input logic [31:0] blk, input int hold, input bit noise,
                        output logic [31:0] got, output int lat);
    int t = 0;
    while (!rdy16 && t < 100) begin @(negedge clk); t++; end
    chk("accept_rdy", rdy16, 1);
    v16 = 1'b1; ib16 = blk; m16 = md;
    @(negedge clk);
    v16 = 1'b0; m16 = ~md; ib16 = $urandom;
    adr_q.delete();
    lat = 1;
    while (!ov16 && lat < 200) begin
      adr_q.push_back(int'(ka16));
      v16 = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      ib16 = $urandom;
      @(negedge clk);
      lat++;
    end
    v16 = 1'b0;
    chk("out_valid_seen", ov16, 1);
    got = ob16;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_blk", ob16, got);
      chk("hold_ov", ov16, 1);
      chk("hold_rdy", rdy16, 0);
    end
    or16 = 1'b1;
    @(negedge clk);
    or16 = 1'b0;
    chk("post_take_ov", ov16, 0);
  endtask

  task automatic xfer64(input bit md, input logic [127:0] blk,
                        output logic [127:0] got, output int lat);
    int t = 0;
    while (!rdy64 && t < 100) begin @(negedge clk); t++; end
    chk("accept_rdy64", rdy64, 1);
    v64 = 1'b1; ib64 = blk; m64 = md;
    @(negedge clk);
    v64 = 1'b0; m64 = ~md;
    lat = 1;
    while (!ov64 && lat < 300) begin @(negedge clk); lat++; end
    chk("out_valid_seen64", ov64, 1);
    got = ob64;
    or64 = 1'b1;
    @(negedge clk);
    or64 = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0]  got, blk;
    logic [127:0] got64, e128;
    logic [31:0]  exp_q[$], got_q[$];
    int           acc_q[$];
    int           lat, nacc;
    bit           md;

    v16 = 0; m16 = 0; ib16 = '0; or16 = 0;
    v64 = 0; m64 = 0; ib64 = '0; or64 = 0;
    expand(16, 32, 62'b11111010001001010110000111001101111101000100101011000011100110,
           64'h0100, 64'h0908, 64'h1110, 64'h1918, ks16);
    expand(64, 72, 62'b11010001111001101011011000100000010111000011001010010011101111,
           64'h0706050403020100, 64'h0f0e0d0c0b0a0908,
           64'h1716151413121110, 64'h1f1e1d1c1b1a1918, ks64);

    repeat (2) @(negedge clk);
    chk("rst_rdy", rdy16, 1);
    chk("rst_ov", ov16, 0);
    chk("rst_adr", ka16, 0);
    chk("rst_blk", ob16, 0);
    chk("rst_rdy64", rdy64, 1);
    chk("rst_blk64", ob64, 0);
    res = 1'b0;

    // Known-answer encrypt, immediately after reset release
    xfer16(MODE_ENC, 32'h6565_6877, 0, 0, got, lat);
    chk("kat32_enc", got, 32'hc69b_e9bb);
    chk("lat32", lat, 34);

    xfer16(MODE_DEC, 32'hc69b_e9bb, 0, 0, got, lat);
    chk("kat32_dec", got, 32'h6565_6877);
    chk("trace_len", adr_q.size(), 33);
    for (int i = 0; i < 32 && i < adr_q.size(); i++) chk("dec_trace", adr_q[i], 31 - i);

    // Stall in DONE plus in_valid noise during RUN
    blk = $urandom;
    xfer16(MODE_ENC, blk, 10, 1, got, lat);
    chk("stall_enc", got, simon_ref(16, 32, 0, blk, ks16));
    blk = $urandom;
    xfer16(MODE_DEC, blk, 3, 1, got, lat);
    chk("stall_dec", got, simon_ref(16, 32, 1, blk, ks16));

    for (int r = 0; r < 6; r++) begin
      blk = $urandom;
      md  = 1'($urandom_range(0, 1));
      xfer16(md, blk, int'($urandom_range(0, 2)), 1, got, lat);
      chk("rand_blk", got, simon_ref(16, 32, md, blk, ks16));
      chk("rand_lat", lat, 34);
    end

    // Reset in the middle of RUN
    v16 = 1'b1; ib16 = $urandom; m16 = MODE_ENC;
    @(negedge clk);
    v16 = 1'b0;
    repeat (15) @(negedge clk);
    #2 res = 1'b1;
    #1;
    chk("midrst_rdy", rdy16, 1);
    chk("midrst_ov", ov16, 0);
    chk("midrst_adr", ka16, 0);
    chk("midrst_blk", ob16, 0);
    @(negedge clk);
    res = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("no_spurious_ov", ov16, 0);
    end
    blk = $urandom;
    xfer16(MODE_ENC, blk, 0, 0, got, lat);
    chk("after_rst", got, simon_ref(16, 32, 0, blk, ks16));
    chk("after_rst_lat", lat, 34);

    // Back-to-back with out_ready held high, mode alternating
    nacc = 0; md = 0;
    or16 = 1'b1;
    for (int c = 0; c < 3 * 35 + 20; c++) begin
      if (ov16) got_q.push_back(ob16);
      if (rdy16 && nacc < 3) begin
        blk = $urandom;
        v16 = 1'b1; ib16 = blk; m16 = md;
        e128 = simon_ref(16, 32, md, blk, ks16);
        exp_q.push_back(e128[31:0]);
        acc_q.push_back(c);
        md = ~md;
        nacc++;
      end else begin
        v16 = 1'b0;
        ib16 = $urandom;
      end
      @(negedge clk);
    end
    or16 = 1'b0; v16 = 1'b0;
    chk("b2b_count", got_q.size(), 3);
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) chk("b2b_blk", got_q[i], exp_q[i]);
    for (int i = 1; i < acc_q.size(); i++) chk("b2b_spacing", acc_q[i] - acc_q[i-1], 35);

    // Simon128/256 known answer and round trip
    xfer64(MODE_ENC, 128'h74206e69206d6f6f_6d69732061207369, got64, lat);
    chk("kat128_enc", got64, 128'h8d2b5579afc8a3a0_3bf72a87efe7b868);
    chk("lat128", lat, 74);
    xfer64(MODE_DEC, got64, got64, lat);
    chk("kat128_dec", got64, 128'h74206e69206d6f6f_6d69732061207369);
    e128 = {$urandom, $urandom, $urandom, $urandom};
    xfer64(MODE_DEC, e128, got64, lat);
    chk("rand128_dec", got64, simon_ref(64, 72, 1, e128, ks64));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/simon_core.md
SIMON_CORE -- requirements
Module: simon_core

Interface
REQ-001 Parameter WORD, default 64: Simon word size n in bits; legal values 16, 24, 32, 48, 64; block is 2*WORD bits.
REQ-002 Parameter ROUNDS, default 72: round count T; range 1..2**KAW.
REQ-003 Parameter KAW, default 7: key address width in bits.
REQ-004 Port clk  input  1: single clock; all state is updated on its rising edge.
REQ-005 Port res  input  1: asynchronous, active-high reset.
REQ-006 Port in_valid  input  1: a block is offered on in_block.
REQ-007 Port in_ready  output  1: the core can accept a block.
REQ-008 Port in_block  input  2*WORD: plaintext or ciphertext, packed {x,y} with x in the upper WORD bits.
REQ-009 Port mode  input  1: 0 = encrypt, 1 = decrypt; sampled only at accept.
REQ-010 Port key_adr  output  KAW: round-key index presented to the external key memory.
REQ-011 Port key  input  WORD: round key k[j]; this cycle's value corresponds to the key_adr of the previous cycle (one-cycle synchronous read).
REQ-012 Port out_valid  output  1: out_block holds a finished result.
REQ-013 Port out_ready  input  1: the consumer takes out_block.
REQ-014 Port out_block  output  2*WORD: result, packed {x,y}.

Function
REQ-015 f(a) = (rotl(a,1) AND rotl(a,8)) XOR rotl(a,2); all rotations are modulo WORD.
REQ-016 An encrypt round with key k: x' = y XOR f(x) XOR k, y' = x.
REQ-017 A decrypt round with key k: x' = y, y' = x XOR f(y) XOR k.
REQ-018 FSM states: IDLE, LOAD, RUN, DONE; the FSM is one-hot encoded.
REQ-019 IDLE: in_ready = 1; when in_valid = 1, the core latches in_block and mode, sets key_adr to 0 (encrypt) or ROUNDS-1 (decrypt), and moves to LOAD.
REQ-020 LOAD lasts exactly 1 cycle: key_adr steps once (+1 encrypt, -1 decrypt); no round is applied; next state is RUN.
REQ-021 RUN lasts exactly ROUNDS cycles: one round is applied per cycle using the key input, and key_adr steps each cycle.
REQ-022 RUN round order: encrypt uses k[0]..k[T-1]; decrypt uses k[T-1]..k[0].
REQ-023 After the last round, the FSM moves to DONE.
REQ-024 key_adr saturates at 0 and at ROUNDS-1; it does not wrap, and the value it drives past the last round is don't-care but stays in range.
REQ-025 ROUNDS = 1: LOAD is still taken, and RUN lasts 1 cycle.
REQ-026 DONE: out_valid = 1 and out_block is stable until out_ready = 1, then the FSM returns to IDLE on that edge.
REQ-027 in_ready is 1 only in IDLE; in_valid in any other state is ignored and the datapath is not altered.
REQ-028 Latency is ROUNDS+2 cycles from the accept edge to the first cycle out_valid = 1.
REQ-029 Throughput is one block per ROUNDS+3 cycles when out_ready is held at 1.
REQ-030 out_ready while out_valid = 0 has no effect.
REQ-031 A change on mode after accept has no effect on the block in flight.

Reset
REQ-032 res asynchronously forces: state IDLE, in_ready 1, out_valid 0, key_adr 0, out_block all-zero, latched mode 0.
REQ-033 res asserted in LOAD, RUN or DONE discards the block in flight, and no out_valid is produced for it.
REQ-034 The first accept is possible in the first cycle after res deasserts.

Structure
REQ-035 Package simon_pkg holds the state enum, the mode constants MODE_ENC = 0 and MODE_DEC = 1, and the legal-WORD check function.
REQ-036 Sub-module simon_round (combinational, parameter WORD; inputs x, y, k, mode; outputs x', y') implements REQ-015..REQ-017.
REQ-037 The top level instantiates simon_round once.
REQ-038 An illegal WORD, or ROUNDS > 2**KAW, is an elaboration error.

Verification
REQ-039 Bench: WORD=16, ROUNDS=32, KAW=5, master key 1918 1110 0908 0100, key memory preloaded with the Simon32/64 schedule; encrypt 6565_6877 -> out_block c69b_e9bb, out_valid rises exactly 34 cycles after accept.
REQ-040 Bench: same setup, decrypt c69b_e9bb -> 6565_6877, with key_adr trace 31,30,...,0.
REQ-041 Bench: WORD=64, ROUNDS=72 with the Simon128/256 schedule; encrypt 74206e69206d6f6f_6d69732061207369 -> 8d2b5579afc8a3a0_3bf72a87efe7b868, then decrypt the result back to the plaintext.
REQ-042 Bench: out_ready held 0 for 10 cycles in DONE -> out_block is unchanged and in_ready stays 0; in_valid pulses during RUN are ignored (the checked result is unchanged).
REQ-043 Bench: res asserted in the middle of RUN (round 15) -> outputs take their reset values immediately; the next block completes correctly, with no spurious out_valid.
REQ-044 Bench: back-to-back blocks with out_ready = 1 -> accepts are spaced ROUNDS+3 cycles apart, and mode is toggled between blocks.
